// File: rtl/memory_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : types                                                        |
// | Description : Shared types for the snooping coherence bus, the crossbar    |
// |               and the memory-side directory.                               |
// |               Exports: bus_msg_t, xbar_msg_t, memory_state_t, mem_entry_t, |
// |               is_delay_state().                                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package types;

  localparam int NUM_CPUS       = 4;
  localparam int XLEN           = 6;
  localparam int CACHELINE_SIZE = 8;
  // One extra bit so an id can also name a non-CPU agent.
  localparam int CPU_ID_W       = $clog2(NUM_CPUS) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GETS = 2'd1,
    GETM = 2'd2,
    PUTM = 2'd3
  } bus_tx_t;

  typedef enum logic [1:0] {
    NODATA    = 2'd0,
    DATA      = 2'd1,
    EXCLUSIVE = 2'd2,
    NODATAE   = 2'd3
  } xbar_msg_type_t;

  // MID / MSD / MEORMD are the transient states waiting on the crossbar.
  typedef enum logic [2:0] {
    MI     = 3'd0,
    MS     = 3'd1,
    MEORM  = 3'd2,
    MID    = 3'd3,
    MSD    = 3'd4,
    MEORMD = 3'd5
  } memory_state_t;

  typedef struct packed {
    logic                valid;
    bus_tx_t             bus_tx;
    logic [CPU_ID_W-1:0] source;
    logic [XLEN-1:0]     addr;
  } bus_msg_t;

  typedef struct packed {
    logic                      valid;
    logic                      memory_flag;
    xbar_msg_type_t            msg_type;
    logic [CPU_ID_W-1:0]       destination;
    logic [XLEN-1:0]           addr;
    logic [CACHELINE_SIZE-1:0] data;
  } xbar_msg_t;

  typedef struct packed {
    memory_state_t             state;
    logic [CACHELINE_SIZE-1:0] data;
    logic [$clog2(NUM_CPUS):0] owner;
    logic [NUM_CPUS-1:0]       sharers;
  } mem_entry_t;

  function automatic logic is_delay_state(memory_state_t s);
    return (s == MID) || (s == MSD) || (s == MEORMD);
  endfunction

endpackage : types
`default_nettype wire

// File: rtl/memory_responder_directory.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : memory_directory                                             |
// | Description : Per-block directory storage. One combinational read port     |
// |               addressed by the bus request, one full-entry write port for  |
// |               request-driven updates and a narrow completion update path.  |
// |               When both target the same block the full-entry write wins,   |
// |               because the caller already folded the completion into it.    |
// | Ports       : clk, rst_n (async, active-low)                               |
// |               i_rd_addr / o_rd_entry      - request read port              |
// |               i_wr_en / i_wr_addr / i_wr_entry - request write port        |
// |               i_cpl_*                     - completion update              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module memory_directory
  import types::*;
#(
  parameter int NUM_BLOCKS = 2**XLEN
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [XLEN-1:0]           i_rd_addr,
  output mem_entry_t                o_rd_entry,
  input  logic                      i_wr_en,
  input  logic [XLEN-1:0]           i_wr_addr,
  input  mem_entry_t                i_wr_entry,
  input  logic                      i_cpl_en,
  input  logic [XLEN-1:0]           i_cpl_addr,
  input  memory_state_t             i_cpl_state,
  input  logic                      i_cpl_data_en,
  input  logic [CACHELINE_SIZE-1:0] i_cpl_data,
  input  logic                      i_cpl_clr_owner
);

  mem_entry_t r_mem [NUM_BLOCKS];

  assign o_rd_entry = r_mem[i_rd_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (i_cpl_en) begin
        r_mem[i_cpl_addr].state <= i_cpl_state;
        if (i_cpl_data_en) begin
          r_mem[i_cpl_addr].data <= i_cpl_data;
        end
        if (i_cpl_clr_owner) begin
          r_mem[i_cpl_addr].owner <= '0;
        end
      end
      if (i_wr_en) begin
        r_mem[i_wr_addr] <= i_wr_entry;
      end
    end
  end

endmodule : memory_directory
`default_nettype wire

// File: rtl/memory_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : memory_responder                                             |
// | Description : Memory endpoint of the snooping bus. Applies directory       |
// |               transitions for ordered bus requests, absorbs writebacks /   |
// |               forwards from the crossbar, stalls requests to blocks that   |
// |               wait on data, and returns registered crossbar responses.     |
// | Ports       : clk, rst_n      - clock, async active-low reset              |
// |               bus_msg_i       - ordered bus request                        |
// |               bus_stall_o     - hold request (combinational)               |
// |               xbar_i          - crossbar input (memory_flag qualified)     |
// |               xbar_o          - registered response to a requestor         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module memory_responder #(
  parameter int NUM_CPUS   = types::NUM_CPUS,
  parameter int NUM_BLOCKS = 2**types::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  types::bus_msg_t  bus_msg_i,
  output logic            bus_stall_o,
  input  types::xbar_msg_t xbar_i,
  output types::xbar_msg_t xbar_o
);
  import types::*;

  mem_entry_t          w_rd_entry;
  mem_entry_t          w_cur;
  mem_entry_t          w_next;
  logic                w_req;
  logic                w_accept;
  logic                w_wr_en;
  logic                w_set_pend;
  logic                w_cpl_hit;
  logic                w_cpl_data_en;
  logic                w_cpl_clr_owner;
  memory_state_t       w_cpl_state;
  logic [NUM_CPUS-1:0] w_src_bit;
  logic [NUM_CPUS-1:0] w_own_bit;
  xbar_msg_t           w_rsp;

  // Only one block may be waiting on the crossbar at a time, so its address
  // and transient state live here rather than needing a second read port.
  logic                r_pend_valid;
  logic [XLEN-1:0]     r_pend_addr;
  memory_state_t       r_pend_state;
  xbar_msg_t           r_xbar;

  memory_directory #(
    .NUM_BLOCKS (NUM_BLOCKS)
  ) u_directory (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_rd_addr       (bus_msg_i.addr),
    .o_rd_entry      (w_rd_entry),
    .i_wr_en         (w_wr_en),
    .i_wr_addr       (bus_msg_i.addr),
    .i_wr_entry      (w_next),
    .i_cpl_en        (w_cpl_hit),
    .i_cpl_addr      (r_pend_addr),
    .i_cpl_state     (w_cpl_state),
    .i_cpl_data_en   (w_cpl_data_en),
    .i_cpl_data      (xbar_i.data),
    .i_cpl_clr_owner (w_cpl_clr_owner)
  );

  // Completion decode: only the message type the pending block waits for
  // resolves it; anything else flagged for memory is dropped.
  always_comb begin
    w_cpl_hit       = 1'b0;
    w_cpl_state     = r_pend_state;
    w_cpl_data_en   = 1'b0;
    w_cpl_clr_owner = 1'b0;
    if (xbar_i.valid && xbar_i.memory_flag && r_pend_valid &&
        (xbar_i.addr == r_pend_addr)) begin
      case (r_pend_state)
        MSD: begin
          if (xbar_i.msg_type == DATA) begin
            w_cpl_hit     = 1'b1;
            w_cpl_state   = MS;
            w_cpl_data_en = 1'b1;
          end
        end
        MID: begin
          if (xbar_i.msg_type == DATA) begin
            w_cpl_hit       = 1'b1;
            w_cpl_state     = MI;
            w_cpl_data_en   = 1'b1;
            w_cpl_clr_owner = 1'b1;
          end
        end
        MEORMD: begin
          if (xbar_i.msg_type == NODATA) begin
            w_cpl_hit   = 1'b1;
            w_cpl_state = MEORM;
          end
        end
        default: ;
      endcase
    end
  end

  // The request sees the entry as it stands after this cycle's completion.
  always_comb begin
    w_cur = w_rd_entry;
    if (w_cpl_hit && (bus_msg_i.addr == r_pend_addr)) begin
      w_cur.state = w_cpl_state;
      if (w_cpl_data_en) begin
        w_cur.data = xbar_i.data;
      end
      if (w_cpl_clr_owner) begin
        w_cur.owner = '0;
      end
    end
  end

  assign w_src_bit = NUM_CPUS'(1) << bus_msg_i.source;
  assign w_own_bit = NUM_CPUS'(1) << w_cur.owner;

  assign w_req       = bus_msg_i.valid && (bus_msg_i.bus_tx != IDLE);
  assign bus_stall_o = w_req && is_delay_state(w_cur.state);
  assign w_accept    = w_req && !is_delay_state(w_cur.state);

  always_comb begin
    w_next  = w_cur;
    w_wr_en = 1'b0;
    w_rsp   = '0;
    if (w_accept) begin
      case (bus_msg_i.bus_tx)
        GETS: begin
          case (w_cur.state)
            MI: begin
              w_rsp.valid    = 1'b1;
              w_rsp.msg_type = EXCLUSIVE;
              w_next.state   = MEORM;
              w_next.owner   = bus_msg_i.source;
              w_next.sharers = '0;
              w_wr_en        = 1'b1;
            end
            MS: begin
              w_rsp.valid    = 1'b1;
              w_rsp.msg_type = DATA;
              w_next.sharers = w_cur.sharers | w_src_bit;
              w_wr_en        = 1'b1;
            end
            MEORM: begin
              // Owner supplies the data; memory waits for its copy.
              w_next.state   = MSD;
              w_next.sharers = w_cur.sharers | w_own_bit | w_src_bit;
              w_wr_en        = 1'b1;
            end
            default: ;
          endcase
        end
        GETM: begin
          case (w_cur.state)
            MI, MS: begin
              w_rsp.valid    = 1'b1;
              // An existing sharer is upgrading and already holds the line.
              w_rsp.msg_type = ((w_cur.state == MS) && ((w_cur.sharers & w_src_bit) != '0))
                               ? NODATA : DATA;
              w_next.state   = MEORM;
              w_next.owner   = bus_msg_i.source;
              w_next.sharers = '0;
              w_wr_en        = 1'b1;
            end
            MEORM: begin
              w_next.state = MEORMD;
              w_next.owner = bus_msg_i.source;
              w_wr_en      = 1'b1;
            end
            default: ;
          endcase
        end
        PUTM: begin
          if ((w_cur.state == MEORM) && (w_cur.owner == bus_msg_i.source)) begin
            w_next.state = MID;
            w_wr_en      = 1'b1;
          end
        end
        default: ;
      endcase
      if (w_rsp.valid) begin
        w_rsp.destination = bus_msg_i.source;
        w_rsp.addr        = bus_msg_i.addr;
        w_rsp.data        = (w_rsp.msg_type == NODATA) ? '0 : w_cur.data;
      end
    end
  end

  assign w_set_pend = w_wr_en && is_delay_state(w_next.state);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_valid <= 1'b0;
      r_pend_addr  <= '0;
      r_pend_state <= MI;
    end else if (w_set_pend) begin
      r_pend_valid <= 1'b1;
      r_pend_addr  <= bus_msg_i.addr;
      r_pend_state <= w_next.state;
    end else if (w_cpl_hit) begin
      r_pend_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xbar <= '0;
    end else begin
      r_xbar <= w_rsp;
    end
  end

  assign xbar_o = r_xbar;

endmodule : memory_responder
`default_nettype wire

// File: tb/tb_memory_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_memory_responder                                          |
// | Description : Self-checking bench for memory_responder. Directed steps     |
// |               followed by randomized traffic, checked against a per-block  |
// |               behavioural directory model.                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_memory_responder;
  import types::*;

  logic      clk = 1'b0;
  logic      rst_n;
  bus_msg_t  bus_msg_i;
  logic      bus_stall_o;
  xbar_msg_t xbar_i;
  xbar_msg_t xbar_o;

  int checks = 0;
  int errors = 0;

  memory_responder #(
    .NUM_CPUS   (4),
    .NUM_BLOCKS (64)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus_msg_i   (bus_msg_i),
    .bus_stall_o (bus_stall_o),
    .xbar_i      (xbar_i),
    .xbar_o      (xbar_o)
  );

  always #5 clk = ~clk;

  // Reference directory: one record per block.
  typedef enum int {T_I, T_S, T_EM, T_ID, T_SD, T_EMD} mst_e;
  mst_e         m_st   [64];
  byte unsigned m_data [64];
  int           m_own  [64];
  bit           m_sh   [64][4];

  function automatic bus_msg_t mk_req(bus_tx_t tx, int src, int addr);
    bus_msg_t b;
    b        = '0;
    b.valid  = 1'b1;
    b.bus_tx = tx;
    b.source = CPU_ID_W'(src);
    b.addr   = XLEN'(addr);
    return b;
  endfunction

  function automatic xbar_msg_t mk_cpl(xbar_msg_type_t t, int addr, int data, bit flag);
    xbar_msg_t x;
    x             = '0;
    x.valid       = 1'b1;
    x.memory_flag = flag;
    x.msg_type    = t;
    x.addr        = XLEN'(addr);
    x.data        = CACHELINE_SIZE'(data);
    return x;
  endfunction

  function automatic xbar_msg_t mk_rsp(xbar_msg_type_t t, int dst, int addr, int data);
    xbar_msg_t x;
    x             = '0;
    x.valid       = 1'b1;
    x.msg_type    = t;
    x.destination = CPU_ID_W'(dst);
    x.addr        = XLEN'(addr);
    x.data        = CACHELINE_SIZE'(data);
    return x;
  endfunction

  function automatic bit is_wait(mst_e s);
    return (s == T_ID) || (s == T_SD) || (s == T_EMD);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_st[i]   = T_I;
      m_data[i] = 8'h00;
      m_own[i]  = 0;
      for (int c = 0; c < 4; c++) m_sh[i][c] = 1'b0;
    end
  endtask

  function automatic int find_pending();
    for (int i = 0; i < 64; i++) begin
      if (is_wait(m_st[i])) return i;
    end
    return -1;
  endfunction

  task automatic model_step(input bus_msg_t b, input xbar_msg_t x,
                            output bit stall, output xbar_msg_t rsp);
    int a;
    int s;
    rsp   = '0;
    stall = 1'b0;
    if (x.valid && x.memory_flag) begin
      a = int'(x.addr);
      if (m_st[a] == T_SD && x.msg_type == DATA) begin
        m_st[a] = T_S; m_data[a] = x.data;
      end else if (m_st[a] == T_ID && x.msg_type == DATA) begin
        m_st[a] = T_I; m_data[a] = x.data; m_own[a] = 0;
      end else if (m_st[a] == T_EMD && x.msg_type == NODATA) begin
        m_st[a] = T_EM;
      end
    end
    if (!b.valid || b.bus_tx == IDLE) return;
    a = int'(b.addr);
    s = int'(b.source);
    if (is_wait(m_st[a])) begin
      stall = 1'b1;
      return;
    end
    case (b.bus_tx)
      GETS: begin
        if (m_st[a] == T_I) begin
          rsp = mk_rsp(EXCLUSIVE, s, a, int'(m_data[a]));
          m_st[a] = T_EM; m_own[a] = s;
          for (int c = 0; c < 4; c++) m_sh[a][c] = 1'b0;
        end else if (m_st[a] == T_S) begin
          rsp = mk_rsp(DATA, s, a, int'(m_data[a]));
          m_sh[a][s] = 1'b1;
        end else if (m_st[a] == T_EM) begin
          m_sh[a][m_own[a]] = 1'b1;
          m_sh[a][s]        = 1'b1;
          m_st[a]           = T_SD;
        end
      end
      GETM: begin
        if (m_st[a] == T_I || m_st[a] == T_S) begin
          if (m_st[a] == T_S && m_sh[a][s]) rsp = mk_rsp(NODATA, s, a, 0);
          else                              rsp = mk_rsp(DATA, s, a, int'(m_data[a]));
          m_st[a] = T_EM; m_own[a] = s;
          for (int c = 0; c < 4; c++) m_sh[a][c] = 1'b0;
        end else if (m_st[a] == T_EM) begin
          m_own[a] = s;
          m_st[a]  = T_EMD;
        end
      end
      PUTM: begin
        if (m_st[a] == T_EM && m_own[a] == s) m_st[a] = T_ID;
      end
      default: ;
    endcase
  endtask

  // One bus cycle: drive at posedge+1, check stall mid-cycle, check the
  // registered response at the next posedge+1.
  task automatic do_cycle(input bus_msg_t b, input xbar_msg_t x, input string tag);
    bit        es;
    xbar_msg_t er;
    bus_msg_i = b;
    xbar_i    = x;
    #2;
    model_step(b, x, es, er);
    checks++;
    assert (bus_stall_o === es) else begin
      errors++;
      $error("FAIL %s stall: observed %0b expected %0b", tag, bus_stall_o, es);
    end
    @(posedge clk);
    #1;
    checks++;
    assert (xbar_o === er) else begin
      errors++;
      $error("FAIL %s xbar_o: observed %h expected %h", tag, xbar_o, er);
    end
    bus_msg_i = '0;
    xbar_i    = '0;
  endtask

  function automatic xbar_msg_t junk();
    return mk_cpl(xbar_msg_type_t'($urandom_range(0, 3)), $urandom_range(0, 7),
                  $urandom_range(0, 255), 1'($urandom_range(0, 1)));
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_msg_t b;
    xbar_msg_t x;
    int p;

    bus_msg_i = '0;
    xbar_i    = '0;
    rst_n     = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    assert (xbar_o === '0) else begin
      errors++;
      $error("FAIL reset_xbar: observed %h expected 0", xbar_o);
    end
    rst_n = 1'b1;

    // Ownership, forward, delayed data and upgrade.
    do_cycle(mk_req(GETS, 1, 5), '0, "gets_mi");
    do_cycle(mk_req(GETS, 2, 5), '0, "gets_meorm");
    do_cycle(mk_req(GETS, 3, 5), '0, "gets_held0");
    do_cycle(mk_req(GETS, 3, 5), '0, "gets_held1");
    do_cycle(mk_req(GETS, 3, 5), mk_cpl(DATA, 5, 8'hA5, 1'b1), "cpl_msd");
    do_cycle(mk_req(GETM, 2, 5), '0, "getm_upgrade");

    // Writeback path, ignored PUTM, dropped crossbar traffic.
    do_cycle(mk_req(PUTM, 2, 5), '0, "putm_owner");
    do_cycle(mk_req(PUTM, 0, 6), '0, "putm_mi");
    do_cycle(mk_req(GETS, 0, 5), mk_cpl(DATA, 5, 8'h99, 1'b0), "noflag_drop");
    do_cycle(mk_req(GETS, 0, 5), mk_cpl(NODATA, 5, 0, 1'b1), "wrongtype_drop");
    do_cycle('0, mk_cpl(DATA, 5, 8'h3C, 1'b1), "writeback");
    do_cycle(mk_req(GETS, 0, 5), '0, "gets_after_wb");
    do_cycle(mk_req(GETS, 0, 6), '0, "gets_putm_ignored");

    // Writeback and a held GETS to the same block in the same cycle.
    do_cycle(mk_req(PUTM, 0, 5), '0, "putm2");
    do_cycle(mk_req(GETS, 1, 5), '0, "held_before_wb");
    do_cycle(mk_req(GETS, 1, 5), mk_cpl(DATA, 5, $urandom_range(0, 255), 1'b1), "wb_and_gets");

    // Ownership transfer through MEORMD, then non-sharer GETM from MS.
    do_cycle(mk_req(GETM, 2, 5), '0, "getm_meorm");
    do_cycle(mk_req(GETS, 3, 5), '0, "held_meormd");
    do_cycle(mk_req(GETS, 3, 5), mk_cpl(NODATA, 5, 0, 1'b1), "nodata_cpl");
    do_cycle('0, mk_cpl(DATA, 5, 8'h11, 1'b1), "fwd_data");
    do_cycle(mk_req(GETM, 0, 5), '0, "getm_ms_nonsharer");

    // Unqualified requests change nothing.
    b = mk_req(GETM, 1, 7);
    b.valid = 1'b0;
    do_cycle(b, '0, "invalid_req");
    do_cycle(mk_req(IDLE, 1, 7), '0, "idle_req");
    do_cycle(mk_req(GETS, 2, 7), '0, "gets_after_noop");

    // Random traffic over a few blocks, at most one block pending.
    for (int n = 0; n < 400; n++) begin
      p = find_pending();
      b = mk_req(bus_tx_t'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 7));
      b.valid = ($urandom_range(0, 9) != 0);
      if (p >= 0) begin
        if ($urandom_range(0, 3) == 0) begin
          b.addr = XLEN'(p);
          x = junk();
        end else begin
          x = mk_cpl((m_st[p] == T_EMD) ? NODATA : DATA, p, $urandom_range(0, 255), 1'b1);
          if ($urandom_range(0, 1) == 1) b.addr = XLEN'(p);
        end
      end else begin
        x = junk();
      end
      do_cycle(b, x, "random");
    end

    // Asynchronous reset with a forward pending and a response in flight.
    do_cycle(mk_req(GETS, 1, 9), '0, "pre_rst_own");
    do_cycle(mk_req(GETS, 2, 9), '0, "pre_rst_fwd");
    do_cycle(mk_req(GETS, 3, 10), '0, "pre_rst_inflight");
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    assert (xbar_o === '0) else begin
      errors++;
      $error("FAIL async_rst_xbar: observed %h expected 0", xbar_o);
    end
    bus_msg_i = mk_req(GETS, 3, 9);
    #1;
    checks++;
    assert (bus_stall_o === 1'b0) else begin
      errors++;
      $error("FAIL async_rst_stall: observed %0b expected 0", bus_stall_o);
    end
    bus_msg_i = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_cycle(mk_req(GETS, 3, 9), '0, "post_rst_gets");
    do_cycle(mk_req(GETS, 0, 10), '0, "post_rst_gets2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_memory_responder
`default_nettype wire
